// File: rtl/branch_predictor_if.sv
// Fetch/branch-unit side bundle for branch_predictor: prediction lookup,
// resolved-outcome training, stall/init control and a state debug tap.
interface branch_predictor_if #(
  parameter int XLEN = 32
);
  logic            stall_i;
  logic            init_req_i;
  logic            busy_o;
  logic [XLEN-1:0] fetch_pc_i;
  logic            pred_taken_o;
  logic [XLEN-1:0] pred_target_o;
  logic            upd_valid_i;
  logic [XLEN-1:0] upd_pc_i;
  logic            upd_is_cond_i;
  logic            upd_taken_i;
  logic [XLEN-1:0] upd_target_i;
  logic [0:0]      dbg_state_o;

  // Updates are level-qualified: a resolved instruction is consumed on any
  // rising edge where upd_valid_i is high and stall_i is low; there is no ready.
  modport master (
    output stall_i, init_req_i, fetch_pc_i,
    output upd_valid_i, upd_pc_i, upd_is_cond_i, upd_taken_i, upd_target_i,
    input  busy_o, pred_taken_o, pred_target_o, dbg_state_o
  );

  modport slave (
    input  stall_i, init_req_i, fetch_pc_i,
    input  upd_valid_i, upd_pc_i, upd_is_cond_i, upd_taken_i, upd_target_i,
    output busy_o, pred_taken_o, pred_target_o, dbg_state_o
  );
endinterface

// File: rtl/branch_predictor.sv
// Bimodal (or gshare when BP_GSHARE_EN is defined) 2-bit BHT plus direct-mapped
// BTB, with a self-sequenced table sweep after reset or an init request.
module branch_predictor #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int BTB_ENTRIES = 16,
  parameter int GHR_BITS    = 6
) (
  input  logic              clock_i,
  input  logic              nreset_i,
  branch_predictor_if.slave bp
);
  localparam int BHT_IW   = $clog2(BHT_ENTRIES);
  localparam int BTB_IW   = $clog2(BTB_ENTRIES);
  localparam int TAG_W    = XLEN - BTB_IW - 2;
  localparam int INIT_LEN = (BHT_ENTRIES > BTB_ENTRIES) ? BHT_ENTRIES : BTB_ENTRIES;
  localparam int INIT_IW  = $clog2(INIT_LEN);
  localparam logic [INIT_IW-1:0] INIT_LAST = INIT_IW'(INIT_LEN - 1);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [INIT_IW-1:0] init_idx_q, init_idx_d;

  logic [1:0]       bht_q        [BHT_ENTRIES];
  logic             btb_valid_q  [BTB_ENTRIES];
  logic [TAG_W-1:0] btb_tag_q    [BTB_ENTRIES];
  logic [XLEN-1:0]  btb_target_q [BTB_ENTRIES];
  logic             btb_jump_q   [BTB_ENTRIES];

  logic [BHT_IW-1:0] hist;
  logic              do_upd;

  assign do_upd = (state_q == ST_RUN) && bp.upd_valid_i && !bp.stall_i;

`ifdef BP_GSHARE_EN
  logic [GHR_BITS-1:0] ghr_q, ghr_d;

  always_comb begin
    ghr_d = ghr_q;
    if (state_q == ST_INIT) ghr_d = '0;
    else if (do_upd && bp.upd_is_cond_i) ghr_d = (ghr_q << 1) | GHR_BITS'(bp.upd_taken_i);
  end

  always_ff @(posedge clock_i or negedge nreset_i) begin
    if (!nreset_i) ghr_q <= '0;
    else           ghr_q <= ghr_d;
  end

  assign hist = BHT_IW'(ghr_q);
`else
  localparam int unused_ghr_bits = GHR_BITS;
  assign hist = '0;
`endif

  // Lookup side: purely combinational, reads table state before any same-cycle write.
  logic [BHT_IW-1:0] f_bi;
  logic [BTB_IW-1:0] f_ti;
  logic              f_hit;
  logic              f_taken;

  assign f_bi    = bp.fetch_pc_i[BHT_IW+1:2] ^ hist;
  assign f_ti    = bp.fetch_pc_i[BTB_IW+1:2];
  assign f_hit   = btb_valid_q[f_ti] && (btb_tag_q[f_ti] == bp.fetch_pc_i[XLEN-1:BTB_IW+2]);
  assign f_taken = (state_q == ST_RUN) && f_hit && (btb_jump_q[f_ti] || bht_q[f_bi][1]);

  assign bp.pred_taken_o  = f_taken;
  assign bp.pred_target_o = f_taken ? btb_target_q[f_ti] : bp.fetch_pc_i + XLEN'(4);
  assign bp.busy_o        = (state_q == ST_INIT);
  assign bp.dbg_state_o   = state_q;

  logic [BHT_IW-1:0] u_bi;
  logic [BTB_IW-1:0] u_ti;
  logic [1:0]        u_cnt;
  logic [1:0]        u_cnt_next;

  assign u_bi  = bp.upd_pc_i[BHT_IW+1:2] ^ hist;
  assign u_ti  = bp.upd_pc_i[BTB_IW+1:2];
  assign u_cnt = bht_q[u_bi];

  always_comb begin
    u_cnt_next = u_cnt;
    if (bp.upd_taken_i) begin
      if (u_cnt != 2'b11) u_cnt_next = u_cnt + 2'b01;
    end else begin
      if (u_cnt != 2'b00) u_cnt_next = u_cnt - 2'b01;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    if (state_q == ST_INIT) begin
      if (bp.init_req_i) begin
        init_idx_d = '0;
      end else if (init_idx_q == INIT_LAST) begin
        state_d    = ST_RUN;
        init_idx_d = '0;
      end else begin
        init_idx_d = init_idx_q + 1'b1;
      end
    end else if (bp.init_req_i) begin
      state_d    = ST_INIT;
      init_idx_d = '0;
    end
  end

  always_ff @(posedge clock_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q    <= ST_INIT;
      init_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
    end
  end

  // Table storage needs no reset: the sweep always runs before RUN is reachable.
  always_ff @(posedge clock_i) begin
    if (state_q == ST_INIT) begin
      if (32'(init_idx_q) < BHT_ENTRIES) bht_q[init_idx_q[BHT_IW-1:0]] <= 2'b01;
      btb_valid_q[init_idx_q[BTB_IW-1:0]] <= 1'b0;
    end else if (do_upd) begin
      if (bp.upd_is_cond_i) bht_q[u_bi] <= u_cnt_next;
      if (bp.upd_taken_i) begin
        btb_valid_q[u_ti]  <= 1'b1;
        btb_tag_q[u_ti]    <= bp.upd_pc_i[XLEN-1:BTB_IW+2];
        btb_target_q[u_ti] <= bp.upd_target_i;
        btb_jump_q[u_ti]   <= !bp.upd_is_cond_i;
      end
    end
  end

  logic unused_pc_bits;
  assign unused_pc_bits = ^{bp.fetch_pc_i[1:0], bp.upd_pc_i[1:0]};
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (default bimodal build, 64 BHT / 16 BTB).
module tb_branch_predictor;
  logic clk;
  logic rst_n;
  logic chk_req;

  branch_predictor_if #(.XLEN(32)) bpi ();

  branch_predictor #(
    .XLEN(32), .BHT_ENTRIES(64), .BTB_ENTRIES(16), .GHR_BITS(6)
  ) dut (
    .clock_i  (clk),
    .nreset_i (rst_n),
    .bp       (bpi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: {busy, taken, target}
  logic [33:0] exp_q[$];
  string       nm_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  always @(negedge clk) begin
    if (chk_req) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL monitor: output presented with empty expected queue");
      end else begin
        logic [33:0] e;
        logic [33:0] g;
        string       n;
        e = exp_q.pop_front();
        n = nm_q.pop_front();
        g = {bpi.busy_o, bpi.pred_taken_o, bpi.pred_target_o};
        if (g !== e) begin
          n_err++;
          $display("FAIL %s: got busy=%0b taken=%0b target=%h, expected busy=%0b taken=%0b target=%h",
                   n, g[33], g[32], g[31:0], e[33], e[32], e[31:0]);
        end
      end
    end
  end

  task automatic step(input string nm, input logic [31:0] pc,
                      input logic eb, input logic et, input logic [31:0] etg,
                      input logic uv, input logic [31:0] upc, input logic ucond,
                      input logic utk, input logic [31:0] utgt,
                      input logic st, input logic ir);
    bpi.fetch_pc_i    = pc;
    bpi.upd_valid_i   = uv;
    bpi.upd_pc_i      = upc;
    bpi.upd_is_cond_i = ucond;
    bpi.upd_taken_i   = utk;
    bpi.upd_target_i  = utgt;
    bpi.stall_i       = st;
    bpi.init_req_i    = ir;
    exp_q.push_back({eb, et, etg});
    nm_q.push_back(nm);
    chk_req = 1'b1;
    @(posedge clk);
    #1;
    chk_req         = 1'b0;
    bpi.upd_valid_i = 1'b0;
    bpi.stall_i     = 1'b0;
    bpi.init_req_i  = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [31:0] pc,
                     input logic eb, input logic et, input logic [31:0] etg);
    step(nm, pc, eb, et, etg, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  // Update while fetching 0x100, which never hits any trained tag.
  task automatic upd(input string nm, input logic [31:0] upc, input logic ucond,
                     input logic utk, input logic [31:0] utgt, input logic st);
    step(nm, 32'h100, 1'b0, 1'b0, 32'h104, 1'b1, upc, ucond, utk, utgt, st, 1'b0);
  endtask

  initial begin
    rst_n             = 1'b0;
    chk_req           = 1'b0;
    bpi.fetch_pc_i    = 32'h100;
    bpi.upd_valid_i   = 1'b0;
    bpi.upd_pc_i      = 32'h0;
    bpi.upd_is_cond_i = 1'b0;
    bpi.upd_taken_i   = 1'b0;
    bpi.upd_target_i  = 32'h0;
    bpi.stall_i       = 1'b0;
    bpi.init_req_i    = 1'b0;
    @(posedge clk);
    #1;

    chk("reset_a", 32'h100, 1'b1, 1'b0, 32'h104);
    chk("reset_b", 32'h100, 1'b1, 1'b0, 32'h104);
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) chk($sformatf("init_busy_%0d", i), 32'h100, 1'b1, 1'b0, 32'h104);
    chk("init_done", 32'h100, 1'b0, 1'b0, 32'h104);

    // Counter walk on index 0 (PC 0x200): 01 ->10 ->11 ->10 ->01 ->10
    upd("t1", 32'h200, 1'b1, 1'b1, 32'h180, 1'b0);
    chk("c10_a", 32'h200, 1'b0, 1'b1, 32'h180);
    upd("t2", 32'h200, 1'b1, 1'b1, 32'h180, 1'b0);
    chk("c11", 32'h200, 1'b0, 1'b1, 32'h180);
    upd("n1", 32'h200, 1'b1, 1'b0, 32'h204, 1'b0);
    chk("c10_b", 32'h200, 1'b0, 1'b1, 32'h180);
    upd("n2", 32'h200, 1'b1, 1'b0, 32'h204, 1'b0);
    chk("c01", 32'h200, 1'b0, 1'b0, 32'h204);
    upd("t3", 32'h200, 1'b1, 1'b1, 32'h180, 1'b0);
    chk("c10_c", 32'h200, 1'b0, 1'b1, 32'h180);

    // Saturation at 3 then at 0
    for (int i = 0; i < 3; i++) upd("cap_t", 32'h200, 1'b1, 1'b1, 32'h180, 1'b0);
    upd("cap_n1", 32'h200, 1'b1, 1'b0, 32'h204, 1'b0);
    chk("cap_10", 32'h200, 1'b0, 1'b1, 32'h180);
    upd("cap_n2", 32'h200, 1'b1, 1'b0, 32'h204, 1'b0);
    chk("cap_01", 32'h200, 1'b0, 1'b0, 32'h204);
    for (int i = 0; i < 3; i++) upd("flr_n", 32'h200, 1'b1, 1'b0, 32'h204, 1'b0);
    upd("flr_t1", 32'h200, 1'b1, 1'b1, 32'h180, 1'b0);
    chk("flr_01", 32'h200, 1'b0, 1'b0, 32'h204);
    upd("flr_t2", 32'h200, 1'b1, 1'b1, 32'h180, 1'b0);
    chk("flr_10", 32'h200, 1'b0, 1'b1, 32'h180);

    // JAL shares BTB index 0 with 0x200 and evicts it
    upd("jal", 32'h300, 1'b0, 1'b1, 32'h400, 1'b0);
    chk("jal_hit", 32'h300, 1'b0, 1'b1, 32'h400);
    chk("jal_evict", 32'h200, 1'b0, 1'b0, 32'h204);
    upd("stall_br", 32'h200, 1'b1, 1'b1, 32'h180, 1'b1);
    upd("stall_jal", 32'h300, 1'b0, 1'b1, 32'h500, 1'b1);
    chk("stall_br_chk", 32'h200, 1'b0, 1'b0, 32'h204);
    chk("stall_jal_chk", 32'h300, 1'b0, 1'b1, 32'h400);

    // Alias: 0x200 and 0x240 share BTB index 0 with different tags
    upd("al_200", 32'h200, 1'b1, 1'b1, 32'h180, 1'b0);
    chk("al_200_hit", 32'h200, 1'b0, 1'b1, 32'h180);
    upd("al_240", 32'h240, 1'b1, 1'b1, 32'h280, 1'b0);
    chk("al_200_miss", 32'h200, 1'b0, 1'b0, 32'h204);
    chk("al_240_hit", 32'h240, 1'b0, 1'b1, 32'h280);
    upd("nt_280", 32'h280, 1'b1, 1'b0, 32'h284, 1'b0);
    chk("nt_keeps_btb", 32'h240, 1'b0, 1'b1, 32'h280);
    chk("nt_no_alloc", 32'h280, 1'b0, 1'b0, 32'h284);
    chk("pc_wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000);

    // Same-cycle lookup and update: old contents are seen
    step("no_bypass", 32'h500, 1'b0, 1'b0, 32'h504, 1'b1, 32'h500, 1'b0, 1'b1, 32'h600, 1'b0, 1'b0);
    chk("after_bypass", 32'h500, 1'b0, 1'b1, 32'h600);
    upd("jal_304", 32'h304, 1'b0, 1'b1, 32'h700, 1'b0);
    chk("jal_304_hit", 32'h304, 1'b0, 1'b1, 32'h700);

    // Init request, restarted mid-sweep by a second pulse
    step("ireq", 32'h304, 1'b0, 1'b1, 32'h700, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) chk($sformatf("ireq_busy_%0d", i), 32'h304, 1'b1, 1'b0, 32'h308);
    step("ireq_restart", 32'h304, 1'b1, 1'b0, 32'h308, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 64; i++) chk($sformatf("reinit_busy_%0d", i), 32'h304, 1'b1, 1'b0, 32'h308);
    chk("reinit_304", 32'h304, 1'b0, 1'b0, 32'h308);
    chk("reinit_500", 32'h500, 1'b0, 1'b0, 32'h504);
    chk("reinit_200", 32'h200, 1'b0, 1'b0, 32'h204);

    @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
